duty_ramp_ctrl: RTL and testbench
=================================

# duty_ramp_ctrl

Duty-cycle sequencer between the SPI register bank and the PWM peripheral. Instead of applying a newly written duty value in one step, it moves the duty driven into the PWM peripheral toward the SPI-written target in programmable steps at a programmable rate, which gives soft-start and fade on the PWM outputs. In bypass mode it passes the target through with one cycle of latency.

## Interface
Parameters:
- `PERIOD_W`, default 16: width of the step-period counter and of `step_period`.

Ports:
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `target_duty`  in  8  requested duty cycle, 0–255.
- `target_valid`  in  1  single-cycle pulse: `target_duty` is new and must be captured.
- `step_size`  in  8  amount `duty_out` changes per step; 0 is treated as 1.
- `step_period`  in  PERIOD_W  clock cycles between steps; 0 selects bypass.
- `ramp_en`  in  1  1 = ramp toward the target, 0 = bypass.
- `duty_out`  out  8  registered duty value; feeds the PWM peripheral's duty input.
- `busy`  out  1  high while a ramp is in progress.
- `done`  out  1  single-cycle pulse when `duty_out` reaches the target.

## Operation
- **Reset:** `duty_out`=0, `busy`=0, `done`=0, latched target=0, counter=0, state IDLE.
- **States:**
  - IDLE: `busy`=0.
  - RAMP: `busy`=1; the counter counts clock edges between steps.
- **Capture:** on any edge where `target_valid`=1, latch `target_duty`. This happens in both states.
- **Bypass** (`ramp_en`=0 or `step_period`=0, evaluated at the capturing edge):
  - `duty_out` is loaded with the target on that same edge.
  - `done`=1 for the following cycle.
  - State stays or returns to IDLE.
- **Ramp start:** if the captured target equals `duty_out`, pulse `done` and stay in IDLE. Otherwise enter RAMP and load counter = `step_period`.
- **RAMP:**
  - The counter decrements each edge.
  - On the edge where counter==1, a step is applied and the counter reloads with `step_period`.
  - Step rule, with d = |target − `duty_out`| and s = max(`step_size`,1):
    - if d ≤ s, `duty_out` becomes the target, `done` pulses and the state returns to IDLE;
    - otherwise `duty_out` moves by s toward the target.
- **Arithmetic:** compute in 9 bits. `duty_out` never overshoots the target and never wraps past 0 or 255.
- **Retarget mid-ramp:** `target_valid` in RAMP replaces the target.
  - The counter is not reloaded.
  - Stepping continues from the current `duty_out` and may reverse direction.
  - If the new target equals `duty_out`, `done` pulses next cycle and the state returns to IDLE.
- **Simultaneous step and `target_valid`:** the step uses the new target.
- **`ramp_en` dropped during RAMP:** the next edge loads `duty_out` with the target, pulses `done` and returns to IDLE.
- **`step_size` and `step_period` changes:** sampled live. A new `step_period` takes effect at the next counter reload.
- **Reset mid-ramp:** all outputs return to their reset values immediately. No `done` pulse.

## Timing
- **Bypass latency:** `target_valid` sampled at edge N gives `duty_out` updated at edge N and `done` high during cycle N..N+1.
- **Ramp cadence:** with `target_valid` at edge N and `step_period`=P:
  - the first step lands at edge N+P;
  - subsequent steps land every P edges.
- **Ramp duration:** ceil(d/s) steps, i.e. ceil(d/s)·P cycles.
- **`done`:** asserted in the cycle after the edge that makes `duty_out` equal the target. Never asserted for more than one cycle.
- **`busy`:** rises the cycle after the capturing edge and falls together with the `done` assertion.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `duty_out`=0, `busy`=0, `done`=0 without waiting for a clock edge. Release, then apply 20 idle clocks → outputs unchanged.
- **Bypass:** `ramp_en`=0, pulse `target_valid` with `target_duty`=200 → `duty_out`=200 one edge later, a single `done` pulse, `busy` never high.
- **Ramp up:** start at duty 0; `ramp_en`=1, `step_size`=30, `step_period`=4, target 100 → `duty_out` = 30, 60, 90, 100 at edges N+4, N+8, N+12, N+16. `done` pulses once after the last step; `busy` is high for 16 cycles.
- **Ramp down with clamp:** duty 250, target 3, `step_size`=100, `step_period`=2 → 150, 50, 3 with no wrap. Repeat with `step_size`=0 and target 247 → decrements by 1 every 2 cycles.
- **Retarget:** during a 0→200 ramp at duty 90, pulse target 40 → next step goes to 60 (step 30), then 40, then `done`. The counter cadence is unbroken.
- **Reset mid-ramp and bypass mid-ramp:**
  - mid-ramp `rst` → `duty_out`=0, state IDLE, no `done`;
  - deassert `ramp_en` mid-ramp → `duty_out`=target on the next edge, with `done`.

Source files
------------

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: moves duty_out toward a captured target in timed steps, or bypasses it directly
module duty_ramp_ctrl #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          target_duty,
  input  logic                target_valid,
  input  logic [7:0]          step_size,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic                ramp_en,
  output logic [7:0]          duty_out,
  output logic                busy,
  output logic                done
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state, state_n;
  logic [7:0] tgt, tgt_n, duty_n, t, s, d;
  logic [8:0] up, dn;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic done_n, bypass;
  always_comb begin
    t = target_valid ? target_duty : tgt;
    s = (step_size == 8'd0) ? 8'd1 : step_size;
    d = (t > duty_out) ? t - duty_out : duty_out - t;
    up = {1'b0, duty_out} + {1'b0, s};
    dn = {1'b0, duty_out} - {1'b0, s};
    bypass = !ramp_en || (target_valid && step_period == '0);
    state_n = state;
    tgt_n = t;
    duty_n = duty_out;
    cnt_n = cnt;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (target_valid) begin
        if (bypass || target_duty == duty_out) begin
          duty_n = target_duty;
          done_n = 1'b1;
        end else begin
          state_n = RAMP;
          cnt_n = step_period;
        end
      end
    end else if (bypass || (target_valid && t == duty_out)) begin
      duty_n = t;
      done_n = 1'b1;
      state_n = IDLE;
    end else if (cnt <= PERIOD_W'(1)) begin
      // a zero period reloaded mid-ramp steps every edge instead of stalling
      cnt_n = step_period;
      if (d <= s) begin
        duty_n = t;
        done_n = 1'b1;
        state_n = IDLE;
      end else begin
        duty_n = (t > duty_out) ? (up[8] ? 8'hFF : up[7:0]) : (dn[8] ? 8'h00 : dn[7:0]);
      end
    end else begin
      cnt_n = cnt - PERIOD_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tgt <= '0;
      duty_out <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tgt <= tgt_n;
      duty_out <= duty_n;
      cnt <= cnt_n;
      done <= done_n;
    end
  end
  assign busy = (state == RAMP);
endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// tb_duty_ramp_ctrl: directed stimulus with an edge-counting reference model and literal spot checks
module tb_duty_ramp_ctrl;
  logic clk = 0, rst = 1, target_valid = 0, ramp_en = 1, busy, done;
  logic [7:0] target_duty = 0, step_size = 1, duty_out;
  logic [15:0] step_period = 1;
  int checks = 0, errors = 0;
  bit armed = 0;

  typedef struct {
    int duty, tgt, nxt, e;
    bit ramp, done;
  } model_t;
  model_t m;

  duty_ramp_ctrl #(.PERIOD_W(16)) dut (
    .clk(clk), .rst(rst), .target_duty(target_duty), .target_valid(target_valid),
    .step_size(step_size), .step_period(step_period), .ramp_en(ramp_en),
    .duty_out(duty_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model tracks the absolute edge number of the next scheduled step.
  function automatic model_t step(model_t c, bit tv, int td, bit en, int ss, int sp);
    int t, s, d;
    c.e++;
    c.done = 0;
    t = tv ? td : c.tgt;
    s = (ss == 0) ? 1 : ss;
    d = (t > c.duty) ? t - c.duty : c.duty - t;
    if (c.ramp) begin
      c.tgt = t;
      if (!en || (tv && sp == 0) || (tv && d == 0) || (c.e == c.nxt && d <= s)) begin
        c.duty = t; c.done = 1; c.ramp = 0;
      end else if (c.e == c.nxt) begin
        c.duty = (t > c.duty) ? c.duty + s : c.duty - s;
        c.nxt = c.e + ((sp == 0) ? 1 : sp);
      end
    end else if (tv) begin
      c.tgt = td;
      if (!en || sp == 0 || d == 0) begin
        c.duty = td; c.done = 1;
      end else begin
        c.ramp = 1; c.nxt = c.e + sp;
      end
    end
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else m <= step(m, target_valid, int'(target_duty), ramp_en, int'(step_size), int'(step_period));
  end

  task automatic chk(string n, logic [8:0] a, logic [8:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("model_duty", {1'b0, duty_out}, 9'(m.duty));
      chk("model_busy", {8'b0, busy}, 9'(m.ramp));
      chk("model_done", {8'b0, done}, 9'(m.done));
    end
  end

  task automatic pulse(input logic [7:0] v);
    target_duty = v;
    target_valid = 1;
    @(negedge clk);
    target_valid = 0;
  endtask

  task automatic set_duty(input logic [7:0] v);
    ramp_en = 0;
    pulse(v);
    ramp_en = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    armed = 1;
    chk("rst_duty", {1'b0, duty_out}, 0);
    chk("rst_busy", {8'b0, busy}, 0);
    // async reset mid-ramp, checked before any further clock edge
    step_size = 30; step_period = 4;
    pulse(100);
    repeat (5) @(negedge clk);
    chk("pre_rst_duty", {1'b0, duty_out}, 30);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_duty", {1'b0, duty_out}, 0);
    chk("async_rst_busy", {8'b0, busy}, 0);
    chk("async_rst_done", {8'b0, done}, 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_duty", {1'b0, duty_out}, 0);
    // bypass
    ramp_en = 0;
    pulse(200);
    chk("byp_duty", {1'b0, duty_out}, 200);
    chk("byp_done", {8'b0, done}, 1);
    chk("byp_busy", {8'b0, busy}, 0);
    @(negedge clk);
    chk("byp_done_low", {8'b0, done}, 0);
    ramp_en = 1;
    // ramp up 0 -> 100
    set_duty(0);
    step_size = 30; step_period = 4;
    pulse(100);
    chk("up_busy0", {8'b0, busy}, 1);
    repeat (4) @(negedge clk); chk("up_30", {1'b0, duty_out}, 30);
    repeat (4) @(negedge clk); chk("up_60", {1'b0, duty_out}, 60);
    repeat (4) @(negedge clk); chk("up_90", {1'b0, duty_out}, 90);
    repeat (3) @(negedge clk); chk("up_busy15", {8'b0, busy}, 1);
    @(negedge clk);
    chk("up_100", {1'b0, duty_out}, 100);
    chk("up_done", {8'b0, done}, 1);
    chk("up_busy_end", {8'b0, busy}, 0);
    // ramp down with clamp
    set_duty(250);
    step_size = 100; step_period = 2;
    pulse(3);
    repeat (2) @(negedge clk); chk("dn_150", {1'b0, duty_out}, 150);
    repeat (2) @(negedge clk); chk("dn_50", {1'b0, duty_out}, 50);
    repeat (2) @(negedge clk); chk("dn_3", {1'b0, duty_out}, 3);
    chk("dn_done", {8'b0, done}, 1);
    set_duty(250);
    step_size = 0;
    pulse(247);
    repeat (2) @(negedge clk); chk("dn1_249", {1'b0, duty_out}, 249);
    repeat (2) @(negedge clk); chk("dn1_248", {1'b0, duty_out}, 248);
    repeat (2) @(negedge clk); chk("dn1_247", {1'b0, duty_out}, 247);
    // retarget mid-ramp
    set_duty(0);
    step_size = 30; step_period = 4;
    pulse(200);
    repeat (12) @(negedge clk); chk("rt_90", {1'b0, duty_out}, 90);
    pulse(40);
    repeat (3) @(negedge clk); chk("rt_60", {1'b0, duty_out}, 60);
    repeat (4) @(negedge clk);
    chk("rt_40", {1'b0, duty_out}, 40);
    chk("rt_done", {8'b0, done}, 1);
    // retarget landing on a step edge
    set_duty(0);
    pulse(200);
    repeat (3) @(negedge clk);
    pulse(10);
    chk("sim_10", {1'b0, duty_out}, 10);
    chk("sim_done", {8'b0, done}, 1);
    // ramp_en dropped mid-ramp
    set_duty(0);
    pulse(200);
    repeat (5) @(negedge clk);
    chk("drop_30", {1'b0, duty_out}, 30);
    ramp_en = 0;
    @(negedge clk);
    chk("drop_200", {1'b0, duty_out}, 200);
    chk("drop_done", {8'b0, done}, 1);
    chk("drop_busy", {8'b0, busy}, 0);
    ramp_en = 1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
